// File: rtl/pulse_sync_scheduler.sv
// Round-robin scheduler sharing one pulse-synchronizer crossing between NUM_REQ requesters.
// Each pending event becomes one tx_pulse; the next launch waits for the returned ack (or a timeout).
module pulse_sync_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int CNT_WIDTH   = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_pulse,
    output logic [NUM_REQ-1:0]         req_overflow,
    output logic                       tx_pulse,
    output logic [$clog2(NUM_REQ)-1:0] tx_id,
    input  logic                       ack_pulse,
    output logic                       timeout_err,
    output logic                       busy,
    output logic                       pending_any
);

    localparam int ID_WIDTH    = $clog2(NUM_REQ);
    localparam int TIMER_WIDTH = $clog2(ACK_TIMEOUT);
    localparam logic [CNT_WIDTH-1:0]   CNT_MAX    = '1;
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, LAUNCH, WAIT_ACK} state_t;

    state_t                 state, state_next;
    logic [CNT_WIDTH-1:0]   cnt      [NUM_REQ];
    logic [CNT_WIDTH-1:0]   cnt_next [NUM_REQ];
    logic [NUM_REQ-1:0]     ovf_next;
    logic [NUM_REQ-1:0]     dec_mask;
    logic                   any_next;
    logic [ID_WIDTH-1:0]    rr_ptr;
    logic [ID_WIDTH-1:0]    scan_idx;
    logic [ID_WIDTH-1:0]    grant_idx;
    logic                   grant_found;
    logic [TIMER_WIDTH-1:0] timer;
    logic                   ack_done;
    logic                   timeout_hit;
    logic                   done;

    assign ack_done    = (state == WAIT_ACK) && ack_pulse;
    assign timeout_hit = (state == WAIT_ACK) && !ack_pulse && (timer == TIMER_LAST);
    assign done        = ack_done || timeout_hit;
    assign busy        = (state != IDLE);

    // Round-robin search: first nonzero counter starting just after the last granted index.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            scan_idx = ID_WIDTH'((int'(rr_ptr) + off) % NUM_REQ);
            if (!grant_found && cnt[scan_idx] != '0) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (grant_found) state_next = SETUP;
            SETUP:    state_next = LAUNCH;
            LAUNCH:   state_next = WAIT_ACK;
            WAIT_ACK: if (done) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_pulse    <= 1'b0;
            timeout_err <= 1'b0;
            tx_id       <= '0;
            rr_ptr      <= ID_WIDTH'(NUM_REQ - 1);
            timer       <= '0;
        end else begin
            tx_pulse    <= (state == SETUP);
            timeout_err <= timeout_hit;
            if (state == IDLE && grant_found) tx_id <= grant_idx;
            if (done) rr_ptr <= tx_id;
            if (state == LAUNCH)        timer <= '0;
            else if (state == WAIT_ACK) timer <= timer + 1'b1;
        end
    end

    // A completing grant and a new event on the same index cancel; saturation drops the event.
    always_comb begin
        dec_mask = '0;
        if (done) dec_mask[tx_id] = 1'b1;
        any_next = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_next[i] = cnt[i];
            ovf_next[i] = 1'b0;
            if (req_pulse[i] && !dec_mask[i]) begin
                if (cnt[i] == CNT_MAX) ovf_next[i] = 1'b1;
                else                   cnt_next[i] = cnt[i] + 1'b1;
            end else if (dec_mask[i] && !req_pulse[i] && cnt[i] != '0) begin
                cnt_next[i] = cnt[i] - 1'b1;
            end
            any_next = any_next | (cnt_next[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the counter array is reset explicitly because a reset must discard pending events.
            cnt          <= '{default: '0};
            req_overflow <= '0;
            pending_any  <= 1'b0;
        end else begin
            cnt          <= cnt_next;
            req_overflow <= ovf_next;
            pending_any  <= any_next;
        end
    end

endmodule
